fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
Instruction-fetch stage that owns the program counter and sits upstream of decode/execute. It consumes the execute-stage taken decision and target from the jump/branch comparator: taken = JumpBranch output, target = EX-computed address. It issues requests to the instruction memory, buffers returned instructions against decode stalls, and flushes younger stages on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
i_Clk_1  input  1  clock, rising edge
i_Rst_n_1  input  1  reset, synchronous, active-low
i_JumpBranch_1  input  1  EX-stage taken/jump decision, qualified valid
i_JumpTarget_32  input  32  redirect target; bits [1:0] ignored and treated as 00
i_Stall_1  input  1  decode cannot accept the presented instruction this cycle
o_IMemReq_1  output  1  instruction memory request
o_IMemAddr_32  output  32  request address, word aligned
i_IMemAck_1  input  1  memory accepts request and returns data this cycle
i_IMemData_32  input  32  instruction word, valid when ack=1
o_InstrValid_1  output  1  o_Instr_32/o_InstrPC_32 valid to decode
o_Instr_32  output  32  fetched instruction
o_InstrPC_32  output  32  address of o_Instr_32
o_Flush_1  output  1  kill IF/ID and ID/EX contents at next edge

Behaviour:
- Reset (i_Rst_n_1=0 at edge): fetch PC=RESET_PC; state S_IDLE; o_IMemReq_1=0; o_InstrValid_1=0; o_Instr_32=0; o_InstrPC_32=0; skid empty. o_Flush_1 is forced 0 while reset is low. An outstanding memory request is abandoned; the memory shares this reset.
- Memory handshake: req/addr are held stable until a cycle with ack=1, and are never withdrawn early. Ack is sampled at the clock edge and may arrive in the first req cycle, giving zero-wait operation of one instruction per cycle.
- Output slot: consumed at an edge where valid=1 and stall=0. The slot is free when valid=0 or it is being consumed. The slot is backed by one skid entry.
- States:
  - S_IDLE: req=0. Always goes to S_REQ next cycle, presenting the fetch PC.
  - S_REQ: req=1, addr=fetch PC.
    - On ack with slot free: load slot {data, addr}, valid=1, fetch PC += PC_STEP, stay in S_REQ.
    - On ack with slot not free: write skid, fetch PC += PC_STEP, go to S_HOLD.
  - S_HOLD: req=0. When stall=0: slot <= skid, skid empties, go to S_REQ.
  - S_DISCARD: req=1 with the pre-redirect addr held. Pending target is in the fetch PC. On ack: drop data, go to S_REQ.
- Redirect (i_JumpBranch_1=1) has priority over stall and ack.
  - o_Flush_1 = i_JumpBranch_1 combinationally.
  - At the edge: valid<=0, skid empties, fetch PC<={target[31:2],2'b00}.
  - Next state:
    - S_REQ without ack this cycle goes to S_DISCARD.
    - S_REQ with ack this cycle drops the data and goes to S_REQ.
    - S_IDLE or S_HOLD goes to S_REQ.
    - S_DISCARD updates the pending target. It goes to S_REQ if ack arrived this cycle, otherwise stays in S_DISCARD.
- Returned data is never presented for an address fetched before a redirect.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. There is no overflow flag.
- Latency: redirect edge to target request is 1 cycle with no outstanding request. Request ack to o_InstrValid_1 is 1 cycle.
- Stalled output holds o_Instr_32/o_InstrPC_32 stable.

Decomposition:
- Shared package: state encoding (S_IDLE, S_REQ, S_HOLD, S_DISCARD, 2 bits), RESET_PC default, PC_STEP, NOP constant 32'h0000_0013 for bench/decode use.
- One sub-module: fetch_skid_buffer, a 2-entry (slot + skid) {instr, pc} buffer with load/consume/flush inputs and valid/full outputs.
- Top holds the PC register, FSM and redirect logic.

Test Plan:
- Reset release, zero-wait ack every cycle, no stall -> addrs 0,4,8,12 on consecutive cycles; o_InstrPC_32 trails o_IMemAddr_32 by 1 cycle; valid continuous.
- Stall held 3 cycles while ack arrives -> skid fills, req drops; instr at PC 0x8 held stable on the output; on stall release 0x8 then 0xC are presented, and fetch resumes at 0x10.
- Redirect to 0x100 with no request outstanding -> o_Flush_1=1 that cycle; valid=0 next cycle; next req addr=0x100.
- Redirect to 0x200 while a request to 0x14 is pending 2 more cycles -> req holds 0x14 until ack; that data is never valid at the output; next req addr=0x200.
- Redirect coincident with stall=1 and a full skid -> both entries dropped; no instruction from the old path appears; req addr=target.
- PC at 0xFFFF_FFFC acked -> next req addr 0x0000_0000. Target 0x103 -> req addr 0x100. Reset asserted mid-S_DISCARD -> next req addr=RESET_PC after S_IDLE.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Provides the fetch FSM state encoding, reset/step defaults, the canonical
// NOP encoding (addi x0,x0,0) and a word-alignment helper.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry {instr, pc} buffer between instruction memory and decode.
// The slot entry is what decode sees; the skid entry catches a returned
// instruction that arrives while the slot is occupied and stalled.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             drop both entries (redirect)
//   load              write in_instr/in_pc this cycle
//   consume           slot is taken by decode this cycle (valid & ~stall)
//   in_instr, in_pc   incoming instruction and its address
//   valid             slot holds an instruction
//   full              skid entry is occupied
//   instr, pc         slot contents
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        load,
  input  logic        consume,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        valid,
  output logic        full,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      full       <= 1'b0;
      instr      <= '0;
      pc         <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      full  <= 1'b0;
    end else if (consume) begin
      if (full) begin
        // Skid drains into the slot; a simultaneous load refills the skid.
        instr <= skid_instr;
        pc    <= skid_pc;
        valid <= 1'b1;
        full  <= load;
        if (load) begin
          skid_instr <= in_instr;
          skid_pc    <= in_pc;
        end
      end else if (load) begin
        instr <= in_instr;
        pc    <= in_pc;
        valid <= 1'b1;
      end else begin
        valid <= 1'b0;
      end
    end else if (load) begin
      if (!valid) begin
        instr <= in_instr;
        pc    <= in_pc;
        valid <= 1'b1;
      end else begin
        skid_instr <= in_instr;
        skid_pc    <= in_pc;
        full       <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues instruction memory
// requests, buffers returned words against decode stalls and handles
// EX-stage redirects (flush of younger stages, discard of in-flight data).
// Ports:
//   i_Clk_1, i_Rst_n_1             clock, synchronous active-low reset
//   i_JumpBranch_1, i_JumpTarget_32 redirect request and target
//   i_Stall_1                      decode cannot accept this cycle
//   o_IMemReq_1, o_IMemAddr_32     memory request (held until ack)
//   i_IMemAck_1, i_IMemData_32     memory accept + returned word
//   o_InstrValid_1, o_Instr_32, o_InstrPC_32  instruction to decode
//   o_Flush_1                      kill IF/ID and ID/EX at next edge
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        i_Clk_1,
  input  logic        i_Rst_n_1,
  input  logic        i_JumpBranch_1,
  input  logic [31:0] i_JumpTarget_32,
  input  logic        i_Stall_1,
  output logic        o_IMemReq_1,
  output logic [31:0] o_IMemAddr_32,
  input  logic        i_IMemAck_1,
  input  logic [31:0] i_IMemData_32,
  output logic        o_InstrValid_1,
  output logic [31:0] o_Instr_32,
  output logic [31:0] o_InstrPC_32,
  output logic        o_Flush_1
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  pc_inc;
  logic [31:0]  target;
  logic         ack;
  logic         consume;
  logic         slot_free;
  logic         buf_load;
  logic         skid_full;

  assign ack       = o_IMemReq_1 & i_IMemAck_1;
  assign consume   = o_InstrValid_1 & ~i_Stall_1;
  assign slot_free = ~o_InstrValid_1 | consume;
  assign pc_inc    = fetch_pc + PC_STEP;
  assign target    = align_word(i_JumpTarget_32);
  // Only data for the current path is buffered; S_DISCARD acks are dropped.
  assign buf_load  = (state == S_REQ) & ack & ~i_JumpBranch_1;
  assign o_Flush_1 = i_JumpBranch_1 & i_Rst_n_1;

  fetch_skid_buffer u_buf (
    .clk      (i_Clk_1),
    .rst_n    (i_Rst_n_1),
    .flush    (i_JumpBranch_1),
    .load     (buf_load),
    .consume  (consume),
    .in_instr (i_IMemData_32),
    .in_pc    (o_IMemAddr_32),
    .valid    (o_InstrValid_1),
    .full     (skid_full),
    .instr    (o_Instr_32),
    .pc       (o_InstrPC_32)
  );

  always_ff @(posedge i_Clk_1) begin
    if (!i_Rst_n_1) begin
      state         <= S_IDLE;
      fetch_pc      <= RESET_PC;
      o_IMemReq_1   <= 1'b0;
      o_IMemAddr_32 <= RESET_PC;
    end else if (i_JumpBranch_1) begin
      fetch_pc <= target;
      // An unacked request must stay on the bus, so its return is
      // swallowed in S_DISCARD before the target is requested.
      if ((state == S_REQ || state == S_DISCARD) && !ack) begin
        state       <= S_DISCARD;
        o_IMemReq_1 <= 1'b1;
      end else begin
        state         <= S_REQ;
        o_IMemReq_1   <= 1'b1;
        o_IMemAddr_32 <= target;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state         <= S_REQ;
          o_IMemReq_1   <= 1'b1;
          o_IMemAddr_32 <= fetch_pc;
        end
        S_REQ: begin
          if (ack) begin
            fetch_pc <= pc_inc;
            if (slot_free) begin
              o_IMemAddr_32 <= pc_inc;
            end else begin
              state       <= S_HOLD;
              o_IMemReq_1 <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          // Leave once the skid entry moves into the slot.
          if (consume || !skid_full) begin
            state         <= S_REQ;
            o_IMemReq_1   <= 1'b1;
            o_IMemAddr_32 <= fetch_pc;
          end
        end
        S_DISCARD: begin
          if (ack) begin
            state         <= S_REQ;
            o_IMemAddr_32 <= fetch_pc;
          end
        end
        default: begin
          state       <= S_IDLE;
          o_IMemReq_1 <= 1'b0;
        end
      endcase
    end
  end

endmodule
